// File: rtl/delay_ext_mem_bridge.sv
// Bridges the delay line's per-sample memory port to a waitrequest-based memory master.
// Each sample tick issues at most one write followed by one read, and the read word is held until the next capture.
`timescale 1ns/1ps
module delay_ext_mem_bridge #(
    parameter int DWIDTH     = 16,
    parameter int AWIDTH     = 16,
    parameter int MEM_AWIDTH = 24,
    parameter logic [MEM_AWIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  sample_tick_i,
    input  logic                  write_enable_i,
    input  logic [AWIDTH-1:0]     write_address_i,
    input  logic [DWIDTH-1:0]     writedata_i,
    input  logic [AWIDTH-1:0]     read_address_i,
    output logic [DWIDTH-1:0]     readdata_o,
    output logic [MEM_AWIDTH-1:0] avm_address_o,
    output logic                  avm_write_o,
    output logic [DWIDTH-1:0]     avm_writedata_o,
    output logic                  avm_read_o,
    input  logic                  avm_waitrequest_i,
    input  logic                  avm_readdatavalid_i,
    input  logic [DWIDTH-1:0]     avm_readdata_i,
    output logic                  busy_o,
    output logic                  overrun_o,
    output logic [1:0]            state_o
);

    // Handshake: a request (avm_write_o / avm_read_o) is held with constant address
    // and data while avm_waitrequest_i is high, and is accepted on the first cycle
    // it is low. Read data is returned later by a one-cycle avm_readdatavalid_i.
    localparam logic [1:0] IDLE_S    = 2'd0;
    localparam logic [1:0] WRITE_S   = 2'd1;
    localparam logic [1:0] READ_S    = 2'd2;
    localparam logic [1:0] WAIT_RD_S = 2'd3;

    logic [1:0]            state;
    logic [AWIDTH-1:0]     cap_waddr;
    logic [AWIDTH-1:0]     cap_raddr;
    logic [DWIDTH-1:0]     cap_wdata;
    logic [DWIDTH-1:0]     readdata_q;
    logic                  overrun_q;
    logic [MEM_AWIDTH-1:0] wr_mem_addr;
    logic [MEM_AWIDTH-1:0] rd_mem_addr;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE_S;
            cap_waddr  <= '0;
            cap_raddr  <= '0;
            cap_wdata  <= '0;
            readdata_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            // Ticks arriving mid-transaction are dropped, not queued.
            if (sample_tick_i && (state != IDLE_S)) begin
                overrun_q <= 1'b1;
            end
            case (state)
                IDLE_S: begin
                    if (sample_tick_i) begin
                        cap_waddr <= write_address_i;
                        cap_raddr <= read_address_i;
                        cap_wdata <= writedata_i;
                        state     <= write_enable_i ? WRITE_S : READ_S;
                    end
                end
                WRITE_S: begin
                    if (!avm_waitrequest_i) begin
                        state <= READ_S;
                    end
                end
                READ_S: begin
                    if (!avm_waitrequest_i) begin
                        if (avm_readdatavalid_i) begin
                            readdata_q <= avm_readdata_i;
                            state      <= IDLE_S;
                        end else begin
                            state <= WAIT_RD_S;
                        end
                    end
                end
                WAIT_RD_S: begin
                    if (avm_readdatavalid_i) begin
                        readdata_q <= avm_readdata_i;
                        state      <= IDLE_S;
                    end
                end
                default: state <= IDLE_S;
            endcase
        end
    end

    // Address arithmetic wraps modulo 2**MEM_AWIDTH.
    assign wr_mem_addr = BASE_ADDR + MEM_AWIDTH'(cap_waddr);
    assign rd_mem_addr = BASE_ADDR + MEM_AWIDTH'(cap_raddr);

    always_comb begin
        avm_address_o   = '0;
        avm_writedata_o = '0;
        avm_write_o     = 1'b0;
        avm_read_o      = 1'b0;
        if (state == WRITE_S) begin
            avm_write_o     = 1'b1;
            avm_address_o   = wr_mem_addr;
            avm_writedata_o = cap_wdata;
        end else if (state == READ_S) begin
            avm_read_o    = 1'b1;
            avm_address_o = rd_mem_addr;
        end
    end

    assign readdata_o = readdata_q;
    assign busy_o     = (state != IDLE_S);
    assign overrun_o  = overrun_q;
    assign state_o    = state;

endmodule

// File: tb/tb_delay_ext_mem_bridge.sv
// Directed bench for delay_ext_mem_bridge: vector table against a behavioural memory
// slave, plus hand-written overrun, async-reset and base-address/late-return sequences.
`timescale 1ns/1ps
module tb_delay_ext_mem_bridge;

    typedef struct {
        logic        we;
        logic [15:0] wa;
        logic [15:0] wd;
        logic [15:0] ra;
        logic        pre_en;
        logic [15:0] pre;
        int          ws;
        int          rs;
        int          lat;
        int          lat_total;
        logic [15:0] exp_rd;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A (BASE_ADDR = 0) ----------------
    logic        tick, we_in;
    logic [15:0] wa_in, wd_in, ra_in;
    logic [15:0] readdata, avm_writedata, rdata_a;
    logic [23:0] avm_address;
    logic        avm_write, avm_read, wait_a, rdv_a, busy, overrun;
    logic [1:0]  state_a;

    delay_ext_mem_bridge u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .sample_tick_i(tick),
        .write_enable_i(we_in), .write_address_i(wa_in), .writedata_i(wd_in),
        .read_address_i(ra_in), .readdata_o(readdata), .avm_address_o(avm_address),
        .avm_write_o(avm_write), .avm_writedata_o(avm_writedata), .avm_read_o(avm_read),
        .avm_waitrequest_i(wait_a), .avm_readdatavalid_i(rdv_a), .avm_readdata_i(rdata_a),
        .busy_o(busy), .overrun_o(overrun), .state_o(state_a)
    );

    // ---------------- DUT B (BASE_ADDR = 0x100000) ----------------
    logic        tick_b, wait_b, rdv_b;
    logic [15:0] ra_b, rdata_b, readdata_b, avm_writedata_b;
    logic [23:0] avm_address_b;
    logic        avm_write_b, avm_read_b, busy_b, overrun_b;
    logic [1:0]  state_b;
    logic        zero_we = 1'b0;
    logic [15:0] zero_w = 16'h0;

    delay_ext_mem_bridge #(.BASE_ADDR(24'h100000)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .sample_tick_i(tick_b),
        .write_enable_i(zero_we), .write_address_i(zero_w), .writedata_i(zero_w),
        .read_address_i(ra_b), .readdata_o(readdata_b), .avm_address_o(avm_address_b),
        .avm_write_o(avm_write_b), .avm_writedata_o(avm_writedata_b), .avm_read_o(avm_read_b),
        .avm_waitrequest_i(wait_b), .avm_readdatavalid_i(rdv_b), .avm_readdata_i(rdata_b),
        .busy_o(busy_b), .overrun_o(overrun_b), .state_o(state_b)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- memory slave model for DUT A ----------------
    logic [15:0] mem [int];
    int wr_stall = 0, rd_stall = 0, rd_lat = 1;
    int wr_acc = 0, rd_acc = 0, stall_err = 0, both_hi = 0;

    initial begin
        int scnt, lim, pend;
        logic stalled;
        logic [23:0] hold_addr;
        logic [15:0] hold_data, pend_data;
        scnt = 0; pend = 0; stalled = 1'b0; hold_addr = '0; hold_data = '0; pend_data = '0;
        wait_a = 1'b0; rdv_a = 1'b0; rdata_a = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wait_a = 1'b0; rdv_a = 1'b0; pend = 0; scnt = 0; stalled = 1'b0;
                continue;
            end
            rdv_a = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    rdv_a = 1'b1;
                    rdata_a = pend_data;
                end
            end
            if (avm_write && avm_read) both_hi++;
            if (avm_write || avm_read) begin
                if (stalled && (avm_address != hold_addr ||
                                (avm_write && avm_writedata != hold_data))) stall_err++;
                lim = avm_write ? wr_stall : rd_stall;
                if (scnt < lim) begin
                    wait_a = 1'b1; scnt++; stalled = 1'b1;
                    hold_addr = avm_address; hold_data = avm_writedata;
                end else begin
                    wait_a = 1'b0; scnt = 0; stalled = 1'b0;
                    if (avm_write) begin
                        mem[int'(avm_address)] = avm_writedata;
                        wr_acc++;
                    end else begin
                        rd_acc++;
                        if (rd_lat == 0) begin
                            rdv_a = 1'b1;
                            rdata_a = mem[int'(avm_address)];
                        end else begin
                            pend = rd_lat;
                            pend_data = mem[int'(avm_address)];
                        end
                    end
                end
            end else begin
                wait_a = 1'b0; scnt = 0; stalled = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_tick(input logic we, input logic [15:0] wa, input logic [15:0] wd,
                           input logic [15:0] ra);
        @(negedge clk);
        we_in = we; wa_in = wa; wd_in = wd; ra_in = ra; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Returns at the negedge of the cycle in which readdata should have updated.
    task automatic run_vec(input vec_t v, input logic [15:0] prev);
        int w0, r0;
        logic [15:0] e;
        if (v.pre_en) mem[int'(v.ra)] = v.pre;
        wr_stall = v.ws; rd_stall = v.rs; rd_lat = v.lat;
        w0 = wr_acc; r0 = rd_acc; stall_err = 0;
        exp_q.push_back(v.exp_rd);
        do_tick(v.we, v.wa, v.wd, v.ra);
        for (int k = 1; k <= v.lat_total; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1) begin
                check("write_req_t1", avm_write, v.we);
                check("read_req_t1", avm_read, !v.we);
                check("req_addr_t1", avm_address, v.we ? v.wa : v.ra);
            end
            if (k == v.lat_total - 1) check("rd_hold_before", readdata, prev);
            if (k == v.lat_total) begin
                e = exp_q.pop_front();
                check("readdata", readdata, e);
                check("busy_done", busy, 0);
            end
        end
        check("write_count", wr_acc - w0, v.we);
        check("read_count", rd_acc - r0, 1);
        check("stall_stable", stall_err, 0);
        check("no_overrun", overrun, 0);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- test ----------------
    vec_t vecs[5];
    vec_t v_post;
    logic [15:0] prev;
    int w0, r0;

    initial begin
        // we, wa, wd, ra, pre_en, pre, ws, rs, lat, lat_total, exp_rd
        vecs[0] = '{1'b1, 16'h0010, 16'h1234, 16'h0010, 1'b0, 16'h0000, 0, 0, 1, 4, 16'h1234};
        vecs[1] = '{1'b0, 16'h0000, 16'h0000, 16'h0005, 1'b1, 16'hBEEF, 0, 0, 1, 3, 16'hBEEF};
        vecs[2] = '{1'b1, 16'h0020, 16'h5A5A, 16'h0021, 1'b1, 16'h0F0F, 3, 2, 1, 9, 16'h0F0F};
        vecs[3] = '{1'b0, 16'h0000, 16'h0000, 16'h0020, 1'b0, 16'h0000, 0, 0, 0, 2, 16'h5A5A};
        vecs[4] = '{1'b1, 16'hFFFF, 16'h8001, 16'h0005, 1'b0, 16'h0000, 0, 1, 2, 6, 16'hBEEF};
        v_post  = '{1'b1, 16'h0040, 16'h7777, 16'h0040, 1'b0, 16'h0000, 0, 0, 1, 4, 16'h7777};

        tick = 1'b0; we_in = 1'b0; wa_in = '0; wd_in = '0; ra_in = '0;
        tick_b = 1'b0; wait_b = 1'b0; rdv_b = 1'b0; rdata_b = '0; ra_b = '0;

        // reset state
        @(negedge clk);
        check("rst_readdata", readdata, 0);
        check("rst_write", avm_write, 0);
        check("rst_read", avm_read, 0);
        check("rst_addr", avm_address, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_state", state_a, 0);
        check("rst_readdata_b", readdata_b, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        prev = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], prev);
            prev = vecs[i].exp_rd;
        end

        // overrun: second tick two cycles after the first
        wr_stall = 0; rd_stall = 0; rd_lat = 1;
        w0 = wr_acc; r0 = rd_acc;
        do_tick(1'b1, 16'h0030, 16'hA1A1, 16'h0030);
        @(negedge clk);
        we_in = 1'b1; wa_in = 16'h0031; wd_in = 16'hDEAD; ra_in = 16'h0031; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("overrun_set", overrun, 1);
        @(negedge clk);
        check("overrun_first_data", readdata, 16'hA1A1);
        repeat (3) @(negedge clk);
        check("overrun_sticky", overrun, 1);
        check("overrun_idle", busy, 0);
        check("overrun_data_held", readdata, 16'hA1A1);
        check("overrun_write_count", wr_acc - w0, 1);
        check("overrun_read_count", rd_acc - r0, 1);

        // async reset while waiting for read data
        rd_lat = 5;
        do_tick(1'b0, 16'h0000, 16'h0000, 16'h0005);
        @(negedge clk);
        check("wait_rd_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_readdata", readdata, 0);
        check("arst_busy", busy, 0);
        check("arst_overrun", overrun, 0);
        check("arst_read", avm_read, 0);
        check("arst_write", avm_write, 0);
        check("arst_addr", avm_address, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(v_post, 16'h0000);

        // base offset, stray strobe and late read return on DUT B
        @(negedge clk);
        rdv_b = 1'b1; rdata_b = 16'h1111;
        @(negedge clk);
        rdv_b = 1'b0;
        check("stray_rdv_ignored", readdata_b, 0);
        ra_b = 16'hFFFF; tick_b = 1'b1;
        @(negedge clk);
        tick_b = 1'b0;
        check("b_read_req", avm_read_b, 1);
        check("b_write_req", avm_write_b, 0);
        check("b_base_addr", avm_address_b, 24'h10FFFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b_rd_hold", readdata_b, 0);
            check("b_busy", busy_b, 1);
        end
        @(negedge clk);
        rdv_b = 1'b1; rdata_b = 16'hC0DE;
        @(negedge clk);
        rdv_b = 1'b0;
        check("b_readdata", readdata_b, 16'hC0DE);
        check("b_idle", busy_b, 0);

        check("never_both_req", both_hi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
